// File: rtl/door_lock_ctrl_param_pkg.sv
// Shared types and helpers for the parametrised keypad door-lock controller.
package door_lock_ctrl_param_pkg;

   // Controller states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENTRY    = 3'd1,
      ST_CHECK    = 3'd2,
      ST_FAIL     = 3'd3,
      ST_UNLOCKED = 3'd4,
      ST_PROG     = 3'd5,
      ST_LOCKOUT  = 3'd6
   } state_t;

   // Output bundle layout: {locked, red_light, green_light, alarm}
   localparam logic [3:0] OUT_RED   = 4'b1100;
   localparam logic [3:0] OUT_CHECK = 4'b1000;
   localparam logic [3:0] OUT_GREEN = 4'b0010;
   localparam logic [3:0] OUT_ALARM = 4'b1101;

   // Decode the light/lock bundle for a given state
   function automatic logic [3:0] f_decode(input state_t st);
      logic [3:0] v;
      case (st)
         ST_IDLE, ST_ENTRY, ST_FAIL: v = OUT_RED;
         ST_CHECK:                   v = OUT_CHECK;
         ST_UNLOCKED, ST_PROG:       v = OUT_GREEN;
         ST_LOCKOUT:                 v = OUT_ALARM;
         default:                    v = OUT_RED;
      endcase
      return v;
   endfunction

   // Largest of three timing parameters, sizes the shared timer
   function automatic int f_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/door_lock_ctrl_param_if.sv
// Keypad inputs and lock/indicator outputs of the door-lock controller.
interface door_lock_ctrl_param_if #(
   parameter int DIGIT_W = 4,
   parameter int CNT_W   = 3,
   parameter int FAIL_W  = 2
);
   logic [DIGIT_W-1:0] i_key_in;
   logic               i_key_valid;
   logic               i_enter;
   logic               i_relock;
   logic               i_prog;
   logic               o_locked;
   logic               o_red_light;
   logic               o_green_light;
   logic               o_alarm;
   logic [FAIL_W-1:0]  o_fail_count;
   logic [CNT_W-1:0]   o_digit_count;

   modport master (
      output i_key_in, i_key_valid, i_enter, i_relock, i_prog,
      input  o_locked, o_red_light, o_green_light, o_alarm, o_fail_count, o_digit_count
   );

   modport slave (
      input  i_key_in, i_key_valid, i_enter, i_relock, i_prog,
      output o_locked, o_red_light, o_green_light, o_alarm, o_fail_count, o_digit_count
   );
endinterface

// File: rtl/door_lock_ctrl_param_timer.sv
// Shared down-timer: load wins, otherwise counts to zero while running.
module lock_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_run,
   output logic         o_expired
);
   logic [W-1:0] r_cnt;

   // Countdown register, holds at zero until reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {W{1'b0}};
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_run && (r_cnt != {W{1'b0}})) begin
         r_cnt <= r_cnt - W'(1'b1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_expired = i_run && (r_cnt == {W{1'b0}});
endmodule

// File: rtl/door_lock_ctrl_param.sv
// Keypad door-lock controller: multi-digit code, retry limit with lockout,
// entry timeout, early relock and code reprogramming around one shared timer.
module door_lock_ctrl_param
   import door_lock_ctrl_param_pkg::*;
#(
   parameter int                            DIGIT_W       = 4,
   parameter int                            CODE_LEN      = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE  = 16'h1234,
   parameter int                            MAX_TRIES     = 3,
   parameter int                            UNLOCK_TIME   = 100,
   parameter int                            LOCKOUT_TIME  = 1000,
   parameter int                            ENTRY_TIMEOUT = 500
) (
   input logic                   clk,
   input logic                   rst_n,
   door_lock_ctrl_param_if.slave bus
);
   localparam int BUF_W   = CODE_LEN * DIGIT_W;
   localparam int CNT_W   = $clog2(CODE_LEN + 1);
   localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
   localparam int TMR_MAX = f_max3(UNLOCK_TIME, LOCKOUT_TIME, ENTRY_TIMEOUT);
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   state_t             r_state, w_state_nxt;
   logic [BUF_W-1:0]   r_buf, w_buf_nxt, w_shift;
   logic [BUF_W-1:0]   r_code, w_code_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_ovr, w_ovr_nxt;
   logic [FAIL_W-1:0]  r_fail, w_fail_nxt, w_fail_inc;
   logic [3:0]         r_out;
   logic               w_take, w_clear, w_full, w_match;
   logic               w_tmr_load, w_tmr_run, w_tmr_exp;
   logic [TMR_W-1:0]   w_tmr_val;

   assign w_full     = (r_cnt == CNT_W'(CODE_LEN));
   assign w_match    = w_full && !r_ovr && (r_buf == r_code);
   assign w_fail_inc = (r_fail >= FAIL_W'(MAX_TRIES)) ? r_fail : r_fail + FAIL_W'(1'b1);
   assign w_shift    = (r_buf << DIGIT_W) | BUF_W'(bus.i_key_in);

   // Next-state, code write and fail counter; enter beats digits and timer expiry
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_fail_nxt  = r_fail;
      w_take      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_key_valid && !bus.i_enter) begin
               w_state_nxt = ST_ENTRY;
               w_take      = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ENTRY: begin
            if (bus.i_enter) begin
               w_state_nxt = ST_CHECK;
            end else if (bus.i_key_valid) begin
               w_take = 1'b1;
            end else if (w_tmr_exp) begin
               w_state_nxt = ST_IDLE;
               w_clear     = 1'b1;
            end else begin
               w_state_nxt = ST_ENTRY;
            end
         end
         ST_CHECK: begin
            w_clear = 1'b1;
            if (w_match) begin
               w_state_nxt = ST_UNLOCKED;
               w_fail_nxt  = {FAIL_W{1'b0}};
            end else if (w_fail_inc == FAIL_W'(MAX_TRIES)) begin
               w_state_nxt = ST_LOCKOUT;
               w_fail_nxt  = w_fail_inc;
            end else begin
               w_state_nxt = ST_FAIL;
               w_fail_nxt  = w_fail_inc;
            end
         end
         ST_FAIL: begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
         end
         ST_UNLOCKED: begin
            if (bus.i_relock || w_tmr_exp) begin
               w_state_nxt = ST_IDLE;
            end else if (bus.i_prog) begin
               w_state_nxt = ST_PROG;
            end else begin
               w_state_nxt = ST_UNLOCKED;
            end
         end
         ST_PROG: begin
            if (bus.i_relock) begin
               w_state_nxt = ST_IDLE;
               w_clear     = 1'b1;
            end else if (bus.i_enter) begin
               w_state_nxt = ST_UNLOCKED;
               w_clear     = 1'b1;
               if (w_full && !r_ovr) begin
                  w_code_nxt = r_buf;
               end else begin
                  w_code_nxt = r_code;
               end
            end else if (bus.i_key_valid) begin
               w_take = 1'b1;
            end else if (w_tmr_exp) begin
               w_state_nxt = ST_UNLOCKED;
               w_clear     = 1'b1;
            end else begin
               w_state_nxt = ST_PROG;
            end
         end
         ST_LOCKOUT: begin
            if (w_tmr_exp) begin
               w_state_nxt = ST_IDLE;
               w_fail_nxt  = {FAIL_W{1'b0}};
            end else begin
               w_state_nxt = ST_LOCKOUT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
         end
      endcase
   end

   // Entry buffer: shift digits in until full, then flag overrun; clear on exit
   always_comb begin
      w_buf_nxt = r_buf;
      w_cnt_nxt = r_cnt;
      w_ovr_nxt = r_ovr;
      if (w_clear) begin
         w_buf_nxt = {BUF_W{1'b0}};
         w_cnt_nxt = {CNT_W{1'b0}};
         w_ovr_nxt = 1'b0;
      end else if (w_take && w_full) begin
         w_ovr_nxt = 1'b1;
      end else if (w_take) begin
         w_buf_nxt = w_shift;
         w_cnt_nxt = r_cnt + CNT_W'(1'b1);
      end else begin
         w_buf_nxt = r_buf;
      end
   end

   // Timer reload on every state change and on each digit strobe during entry
   always_comb begin
      w_tmr_load = (w_state_nxt != r_state) || w_take;
      w_tmr_run  = (r_state == ST_ENTRY) || (r_state == ST_PROG) ||
                   (r_state == ST_UNLOCKED) || (r_state == ST_LOCKOUT);
      case (w_state_nxt)
         ST_ENTRY, ST_PROG: w_tmr_val = TMR_W'(ENTRY_TIMEOUT - 1);
         ST_UNLOCKED:       w_tmr_val = TMR_W'(UNLOCK_TIME - 1);
         ST_LOCKOUT:        w_tmr_val = TMR_W'(LOCKOUT_TIME - 1);
         default:           w_tmr_val = {TMR_W{1'b0}};
      endcase
   end

   lock_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_run      (w_tmr_run),
      .o_expired  (w_tmr_exp)
   );

   // State, buffer, code and counters; outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_buf   <= {BUF_W{1'b0}};
         r_code  <= DEFAULT_CODE;
         r_cnt   <= {CNT_W{1'b0}};
         r_ovr   <= 1'b0;
         r_fail  <= {FAIL_W{1'b0}};
         r_out   <= OUT_RED;
      end else begin
         r_state <= w_state_nxt;
         r_buf   <= w_buf_nxt;
         r_code  <= w_code_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovr   <= w_ovr_nxt;
         r_fail  <= w_fail_nxt;
         r_out   <= f_decode(w_state_nxt);
      end
   end

   assign bus.o_locked      = r_out[3];
   assign bus.o_red_light   = r_out[2];
   assign bus.o_green_light = r_out[1];
   assign bus.o_alarm       = r_out[0];
   assign bus.o_fail_count  = r_fail;
   assign bus.o_digit_count = r_cnt;
endmodule

// File: tb/tb_door_lock_ctrl_param.sv
// Directed bench for door_lock_ctrl_param: vector table plus timing sequences.
module tb_door_lock_ctrl_param;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   door_lock_ctrl_param_if #(.DIGIT_W(4), .CNT_W(3), .FAIL_W(2)) bus ();

   door_lock_ctrl_param dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       kv;
      logic [3:0] key;
      logic       en;
      logic       rl;
      logic       pg;
      logic       lk;
      logic       rd;
      logic       gr;
      logic       al;
      logic [1:0] fc;
      logic [2:0] dc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic kv, input logic [3:0] key, input logic en,
                               input logic rl, input logic pg, input logic lk, input logic rd,
                               input logic gr, input logic al, input logic [1:0] fc,
                               input logic [2:0] dc);
      vec_t v;
      v = '{kv, key, en, rl, pg, lk, rd, gr, al, fc, dc};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic kv, input logic [3:0] k, input logic en,
                        input logic rl, input logic pg);
      @(negedge clk);
      bus.i_key_valid = kv;
      bus.i_key_in    = k;
      bus.i_enter     = en;
      bus.i_relock    = rl;
      bus.i_prog      = pg;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // four digits, most significant first, then enter (leaves DUT in CHECK or UNLOCKED)
   task automatic code_enter(input logic [15:0] code);
      drive(1'b1, code[15:12], 1'b0, 1'b0, 1'b0);
      drive(1'b1, code[11:8],  1'b0, 1'b0, 1'b0);
      drive(1'b1, code[7:4],   1'b0, 1'b0, 1'b0);
      drive(1'b1, code[3:0],   1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0,        1'b1, 1'b0, 1'b0);
   endtask

   // counts consecutive unlocked cycles, current cycle included
   task automatic unlock_len(output int n);
      n = 1;
      for (int i = 0; i < 300; i++) begin
         idle();
         if (bus.o_locked) break;
         n++;
      end
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
   endtask

   initial begin
      int n;
      int stray;
      vec_t v;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.i_key_valid = 1'b0;
      bus.i_key_in    = 4'd0;
      bus.i_enter     = 1'b0;
      bus.i_relock    = 1'b0;
      bus.i_prog      = 1'b0;

      // kv key en rl pg | lk rd gr al fc dc
      tbl.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1));
      tbl.push_back(mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2));
      tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3));
      tbl.push_back(mk(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd4));
      tbl.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4));
      tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0));
      tbl.push_back(mk(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0));
      tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0));
      tbl.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0));
      tbl.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1));
      tbl.push_back(mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2));
      tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3));
      tbl.push_back(mk(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd4));
      tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd4));
      tbl.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4));
      tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd0));
      tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd0));
      tbl.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd1));
      tbl.push_back(mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd2));
      tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3));
      tbl.push_back(mk(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd3));
      tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd0));
      tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd0));
      tbl.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd1));
      tbl.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd2));
      tbl.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd3));
      tbl.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd4));
      tbl.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd4));
      tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 3'd0));

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.locked", bus.o_locked, 1);
      chk("rst.red", bus.o_red_light, 1);
      chk("rst.green", bus.o_green_light, 0);
      chk("rst.alarm", bus.o_alarm, 0);
      chk("rst.fail", bus.o_fail_count, 0);
      chk("rst.digits", bus.o_digit_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // table: unlock, relock priority, overrun, key+enter collision, lockout entry
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v.kv, v.key, v.en, v.rl, v.pg);
         chk($sformatf("vec%0d.locked", i), bus.o_locked, v.lk);
         chk($sformatf("vec%0d.red", i), bus.o_red_light, v.rd);
         chk($sformatf("vec%0d.green", i), bus.o_green_light, v.gr);
         chk($sformatf("vec%0d.alarm", i), bus.o_alarm, v.al);
         chk($sformatf("vec%0d.fail", i), bus.o_fail_count, v.fc);
         chk($sformatf("vec%0d.digits", i), bus.o_digit_count, v.dc);
      end

      // lockout duration with inputs hammering the keypad
      n = 1;
      stray = 0;
      for (int i = 0; i < 1100; i++) begin
         if (i % 6 < 4) drive(1'b1, 4'((i % 6) + 1), 1'b0, 1'b0, 1'b0);
         else if (i % 6 == 4) drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         else drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
         if (!bus.o_alarm) break;
         n++;
         if (bus.o_digit_count != 3'd0 || bus.o_green_light) stray++;
      end
      chk("lockout.cycles", n, 1000);
      chk("lockout.ignored", stray, 0);
      chk("lockout.exit_fail", bus.o_fail_count, 0);
      chk("lockout.exit_locked", bus.o_locked, 1);
      chk("lockout.exit_digits", bus.o_digit_count, 0);

      // correct code: locked falls two edges after enter, unlock lasts 100 cycles
      idle();
      code_enter(16'h1234);
      chk("t1.check_locked", bus.o_locked, 1);
      idle();
      chk("t1.unlocked", bus.o_locked, 0);
      unlock_len(n);
      chk("t1.unlock_cycles", n, 100);
      chk("t1.fail", bus.o_fail_count, 0);

      // reprogram to 9876, timer restarts on successful write
      code_enter(16'h1234);
      idle();
      repeat (50) idle();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      chk("t4.prog_green", bus.o_green_light, 1);
      code_enter(16'h9876);
      chk("t4.write_unlocked", bus.o_locked, 0);
      chk("t4.write_digits", bus.o_digit_count, 0);
      unlock_len(n);
      chk("t4.restart_cycles", n, 100);
      code_enter(16'h1234);
      idle();
      chk("t4.old_code_red", bus.o_red_light, 1);
      chk("t4.old_code_fail", bus.o_fail_count, 1);
      idle();
      code_enter(16'h9876);
      idle();
      chk("t4.new_code_unlock", bus.o_locked, 0);
      chk("t4.new_code_fail", bus.o_fail_count, 0);
      // short entry in PROG leaves code untouched
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      chk("t4.short_green", bus.o_green_light, 1);
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      chk("t4.relock", bus.o_locked, 1);
      code_enter(16'h9876);
      idle();
      chk("t4.code_kept", bus.o_locked, 0);
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

      // entry timeout keeps fail_count
      code_enter(16'h1111);
      idle();
      idle();
      chk("t3.fail_before", bus.o_fail_count, 1);
      drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      repeat (499) idle();
      chk("t3.still_entry", bus.o_digit_count, 2);
      idle();
      chk("t3.timeout_digits", bus.o_digit_count, 0);
      chk("t3.timeout_fail", bus.o_fail_count, 1);
      chk("t3.timeout_red", bus.o_red_light, 1);

      // async reset in LOCKOUT
      code_enter(16'h1111);
      idle();
      idle();
      code_enter(16'h1111);
      idle();
      chk("t6.lockout_alarm", bus.o_alarm, 1);
      repeat (20) idle();
      pulse_reset();
      chk("t6.lo_locked", bus.o_locked, 1);
      chk("t6.lo_alarm", bus.o_alarm, 0);
      chk("t6.lo_fail", bus.o_fail_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      code_enter(16'h1234);
      idle();
      chk("t6.default_code", bus.o_locked, 0);
      // async reset in PROG
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      chk("t6.prog_digits", bus.o_digit_count, 1);
      pulse_reset();
      chk("t6.pr_locked", bus.o_locked, 1);
      chk("t6.pr_green", bus.o_green_light, 0);
      chk("t6.pr_digits", bus.o_digit_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
